// File: rtl/fog_loop_ctrl.sv
// fog_loop_ctrl: closed-loop sequencer for the miniFOG phase-ramp feedback path.
// Demodulates error samples against the modulation half indicator, sums them
// over a window of 2^AVG_LOG2 step triggers, reports the window sum as the
// open-loop rate and, in closed loop, integrates the scaled sum into a
// saturated ramp step word.
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_en               loop enable (low forces IDLE and clears everything)
//   i_trig             one-cycle step trigger, one per modulation half-period
//   i_status           modulation half indicator, 1 = high half
//   i_err, i_err_vld   signed error sample and its valid strobe
//   i_gain_sft         arithmetic right shift applied to the window sum
//   i_fb_req           closed-loop request, sampled only at window close
//   o_step             signed step word to the ramp generator
//   o_fb_on            feedback enable to the ramp generator
//   o_rate, o_rate_vld last window sum and its one-cycle update pulse
//   o_state            0 IDLE, 1 SETTLE, 2 OPEN, 3 CLOSED
module fog_loop_ctrl #(
   parameter int unsigned ERR_BIT    = 14,
   parameter int unsigned SETTLE_CNT = 16,
   parameter int unsigned AVG_LOG2   = 3,
   parameter int unsigned STEP_LIM   = 100000
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic                      i_trig,
   input  logic                      i_status,
   input  logic signed [ERR_BIT-1:0] i_err,
   input  logic                      i_err_vld,
   input  logic [4:0]                i_gain_sft,
   input  logic                      i_fb_req,
   output logic signed [31:0]        o_step,
   output logic                      o_fb_on,
   output logic signed [31:0]        o_rate,
   output logic                      o_rate_vld,
   output logic [1:0]                o_state
);

   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = DW + 1;
   localparam int unsigned SET_W = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
   localparam int unsigned WIN_W = AVG_LOG2 + 1;

   localparam logic [SET_W-1:0]     SET_LAST = SET_W'(SETTLE_CNT - 1);
   localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);
   localparam logic signed [SW-1:0] LIM_P    = SW'(STEP_LIM);
   localparam logic signed [SW-1:0] LIM_N    = -LIM_P;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      OPEN   = 2'd2,
      CLOSED = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic signed [DW-1:0] acc_q, acc_d;
   logic [WIN_W-1:0]     win_q, win_d;
   logic [SET_W-1:0]     set_q, set_d;
   logic signed [DW-1:0] step_q, step_d;
   logic signed [DW-1:0] rate_q, rate_d;
   logic                 rvld_q, rvld_d;
   logic                 fb_q, fb_d;

   logic signed [DW-1:0] err_ext_c;
   logic signed [DW-1:0] acc_sum_c;
   logic signed [DW-1:0] sh_c;
   logic signed [SW-1:0] step_sum_c;
   logic signed [DW-1:0] step_sat_c;
   logic                 close_c;

   // Sign-extended sample, demodulated by the half indicator
   assign err_ext_c = DW'(i_err);

   always_comb begin
      acc_sum_c = acc_q;
      if (i_err_vld) begin
         acc_sum_c = i_status ? (acc_q + err_ext_c) : (acc_q - err_ext_c);
      end
   end

   // Window closes on the trigger completing 2^AVG_LOG2 triggers; the sum
   // includes any sample arriving in the same cycle as that trigger
   assign close_c = ((state_q == OPEN) || (state_q == CLOSED)) && i_trig &&
                    (win_q == WIN_LAST);

   // Integrate scaled window sum, one extra bit so the clamp sees true overflow
   assign sh_c       = acc_sum_c >>> i_gain_sft;
   assign step_sum_c = SW'(step_q) + SW'(sh_c);

   always_comb begin
      if (step_sum_c > LIM_P) begin
         step_sat_c = DW'(LIM_P);
      end else if (step_sum_c < LIM_N) begin
         step_sat_c = DW'(LIM_N);
      end else begin
         step_sat_c = DW'(step_sum_c);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      win_d   = win_q;
      set_d   = set_q;
      step_d  = step_q;
      rate_d  = rate_q;
      rvld_d  = 1'b0;

      if (!i_en) begin
         // Disable wins over a coincident window close
         state_d = IDLE;
         acc_d   = '0;
         win_d   = '0;
         set_d   = '0;
         step_d  = '0;
         rate_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SETTLE;
            end
            SETTLE: begin
               // Samples are discarded here; acc stays at zero
               if (i_trig) begin
                  if (set_q == SET_LAST) begin
                     set_d   = '0;
                     state_d = i_fb_req ? CLOSED : OPEN;
                  end else begin
                     set_d = set_q + SET_W'(1);
                  end
               end
            end
            OPEN, CLOSED: begin
               acc_d = acc_sum_c;
               if (i_trig) begin
                  win_d = win_q + WIN_W'(1);
               end
               if (close_c) begin
                  acc_d  = '0;
                  win_d  = '0;
                  rate_d = acc_sum_c;
                  rvld_d = 1'b1;
                  if (state_q == OPEN) begin
                     // Entry window is reported but not integrated
                     if (i_fb_req) begin
                        state_d = CLOSED;
                     end
                  end else if (i_fb_req) begin
                     step_d = step_sat_c;
                  end else begin
                     state_d = OPEN;
                     step_d  = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      fb_d = (state_d == CLOSED);
   end

   // State and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         win_q   <= '0;
         set_q   <= '0;
         step_q  <= '0;
         rate_q  <= '0;
         rvld_q  <= 1'b0;
         fb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         win_q   <= win_d;
         set_q   <= set_d;
         step_q  <= step_d;
         rate_q  <= rate_d;
         rvld_q  <= rvld_d;
         fb_q    <= fb_d;
      end
   end

   assign o_step     = step_q;
   assign o_fb_on    = fb_q;
   assign o_rate     = rate_q;
   assign o_rate_vld = rvld_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_fog_loop_ctrl.sv
// tb_fog_loop_ctrl: directed bench for fog_loop_ctrl with a short settle
// period, two-trigger windows and a small step limit.
module tb_fog_loop_ctrl;

   logic               i_clk;
   logic               i_rst;
   logic               i_en;
   logic               i_trig;
   logic               i_status;
   logic signed [13:0] i_err;
   logic               i_err_vld;
   logic [4:0]         i_gain_sft;
   logic               i_fb_req;
   logic signed [31:0] o_step;
   logic               o_fb_on;
   logic signed [31:0] o_rate;
   logic               o_rate_vld;
   logic [1:0]         o_state;

   int n_chk = 0;
   int n_err = 0;

   fog_loop_ctrl #(
      .ERR_BIT   (14),
      .SETTLE_CNT(4),
      .AVG_LOG2  (1),
      .STEP_LIM  (100)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_trig    (i_trig),
      .i_status  (i_status),
      .i_err     (i_err),
      .i_err_vld (i_err_vld),
      .i_gain_sft(i_gain_sft),
      .i_fb_req  (i_fb_req),
      .o_step    (o_step),
      .o_fb_on   (o_fb_on),
      .o_rate    (o_rate),
      .o_rate_vld(o_rate_vld),
      .o_state   (o_state)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // One record per modulation half: inputs and outputs expected after its trigger
   typedef struct {
      logic               fb;
      logic [4:0]         g;
      logic               rev;
      logic [1:0]         xs;
      logic signed [31:0] xr;
      logic               xv;
      logic signed [31:0] xstep;
      logic               xfb;
   } vec_t;

   localparam int NV = 36;
   vec_t tbl [NV];

   function automatic vec_t mk(input int fb, input int g, input int rev, input int xs,
                               input int xr, input int xv, input int xstep, input int xfb);
      vec_t v;
      v.fb    = 1'(fb);
      v.g     = 5'(g);
      v.rev   = 1'(rev);
      v.xs    = 2'(xs);
      v.xr    = 32'(xr);
      v.xv    = 1'(xv);
      v.xstep = 32'(xstep);
      v.xfb   = 1'(xfb);
      return v;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_outs(input string nm, input int xs, input int xr, input int xv,
                             input int xstep, input int xfb);
      chk({nm, "_state"}, 32'(o_state), 32'(xs));
      chk({nm, "_rate"}, o_rate, 32'(xr));
      chk({nm, "_vld"}, 32'(o_rate_vld), 32'(xv));
      chk({nm, "_step"}, o_step, 32'(xstep));
      chk({nm, "_fb"}, 32'(o_fb_on), 32'(xfb));
   endtask

   // n sample cycles, then the trigger cycle (optionally with a coincident sample and i_en value)
   task automatic half(input logic st, input logic signed [13:0] e, input int n,
                       input logic cv, input logic signed [13:0] ce, input logic en_t);
      i_status = st;
      for (int k = 0; k < n; k++) begin
         i_err     = e;
         i_err_vld = 1'b1;
         i_trig    = 1'b0;
         tick();
         if (k == 0) chk("vld_quiet", 32'(o_rate_vld), 32'd0);
      end
      i_trig    = 1'b1;
      i_err_vld = cv;
      i_err     = ce;
      i_en      = en_t;
      tick();
      i_trig    = 1'b0;
      i_err_vld = 1'b0;
   endtask

   initial begin
      logic               st;
      logic signed [13:0] e;

      //            fb g rev st rate vld step fb
      tbl[0]  = mk(0, 2, 0, 1,   0, 0,    0, 0);
      tbl[1]  = mk(0, 2, 0, 1,   0, 0,    0, 0);
      tbl[2]  = mk(0, 2, 0, 1,   0, 0,    0, 0);
      tbl[3]  = mk(0, 2, 0, 2,   0, 0,    0, 0);
      tbl[4]  = mk(0, 2, 0, 2,   0, 0,    0, 0);
      tbl[5]  = mk(0, 2, 0, 2,  60, 1,    0, 0);
      tbl[6]  = mk(0, 2, 0, 2,  60, 0,    0, 0);
      tbl[7]  = mk(0, 2, 0, 2,  60, 1,    0, 0);
      tbl[8]  = mk(1, 2, 0, 2,  60, 0,    0, 0);
      tbl[9]  = mk(1, 2, 0, 3,  60, 1,    0, 1);
      tbl[10] = mk(1, 2, 0, 3,  60, 0,    0, 1);
      tbl[11] = mk(1, 2, 0, 3,  60, 1,   15, 1);
      tbl[12] = mk(1, 2, 0, 3,  60, 0,   15, 1);
      tbl[13] = mk(1, 2, 0, 3,  60, 1,   30, 1);
      tbl[14] = mk(1, 2, 0, 3,  60, 0,   30, 1);
      tbl[15] = mk(1, 2, 0, 3,  60, 1,   45, 1);
      tbl[16] = mk(0, 2, 0, 3,  60, 0,   45, 1);
      tbl[17] = mk(0, 2, 0, 2,  60, 1,    0, 0);
      tbl[18] = mk(1, 0, 0, 2,  60, 0,    0, 0);
      tbl[19] = mk(1, 0, 0, 3,  60, 1,    0, 1);
      tbl[20] = mk(1, 0, 0, 3,  60, 0,    0, 1);
      tbl[21] = mk(1, 0, 0, 3,  60, 1,   60, 1);
      tbl[22] = mk(1, 0, 0, 3,  60, 0,   60, 1);
      tbl[23] = mk(1, 0, 0, 3,  60, 1,  100, 1);
      tbl[24] = mk(1, 0, 0, 3,  60, 0,  100, 1);
      tbl[25] = mk(1, 0, 0, 3,  60, 1,  100, 1);
      tbl[26] = mk(1, 0, 1, 3,  60, 0,  100, 1);
      tbl[27] = mk(1, 0, 1, 3, -60, 1,   40, 1);
      tbl[28] = mk(1, 0, 1, 3, -60, 0,   40, 1);
      tbl[29] = mk(1, 0, 1, 3, -60, 1,  -20, 1);
      tbl[30] = mk(1, 0, 1, 3, -60, 0,  -20, 1);
      tbl[31] = mk(1, 0, 1, 3, -60, 1,  -80, 1);
      tbl[32] = mk(1, 0, 1, 3, -60, 0,  -80, 1);
      tbl[33] = mk(1, 0, 1, 3, -60, 1, -100, 1);
      tbl[34] = mk(1, 0, 1, 3, -60, 0, -100, 1);
      tbl[35] = mk(1, 0, 1, 3, -60, 1, -100, 1);

      i_rst      = 1'b1;
      i_en       = 1'b0;
      i_trig     = 1'b0;
      i_status   = 1'b0;
      i_err      = '0;
      i_err_vld  = 1'b0;
      i_gain_sft = '0;
      i_fb_req   = 1'b0;
      tick();
      tick();
      check_outs("reset", 0, 0, 0, 0, 0);
      i_rst = 1'b0;
      i_en  = 1'b1;

      // Settle, open loop, closed-loop integration, drop-out and saturation
      for (int i = 0; i < NV; i++) begin
         i_fb_req   = tbl[i].fb;
         i_gain_sft = tbl[i].g;
         st = (i % 2 == 0);
         e  = st ? 14'sd10 : -14'sd10;
         if (tbl[i].rev) e = -e;
         half(st, e, 3, 1'b0, '0, 1'b1);
         check_outs($sformatf("vec%0d", i), tbl[i].xs, tbl[i].xr, tbl[i].xv,
                    tbl[i].xstep, tbl[i].xfb);
      end

      // Sample coincident with the closing trigger belongs to the closing window
      i_fb_req   = 1'b0;
      i_gain_sft = '0;
      half(1'b0, -14'sd10, 3, 1'b0, '0, 1'b1);
      check_outs("pre_coinc", 3, -60, 0, -100, 1);
      half(1'b1, 14'sd10, 3, 1'b1, 14'sd7, 1'b1);
      check_outs("coinc", 2, 67, 1, 0, 0);
      half(1'b1, 14'sd10, 3, 1'b0, '0, 1'b1);
      half(1'b0, -14'sd10, 3, 1'b0, '0, 1'b1);
      check_outs("post_coinc", 2, 60, 1, 0, 0);

      // Disable coincident with a closing trigger: no report, everything cleared
      half(1'b1, 14'sd10, 3, 1'b0, '0, 1'b1);
      half(1'b0, -14'sd10, 3, 1'b0, '0, 1'b0);
      check_outs("en_drop", 0, 0, 0, 0, 0);
      tick();
      check_outs("idle_hold", 0, 0, 0, 0, 0);

      // Re-enable straight into closed loop
      i_en       = 1'b1;
      i_fb_req   = 1'b1;
      i_gain_sft = 5'd2;
      for (int k = 0; k < 4; k++) begin
         half(k % 2 == 0, (k % 2 == 0) ? 14'sd10 : -14'sd10, 3, 1'b0, '0, 1'b1);
         if (k < 3) chk($sformatf("resettle%0d_state", k), 32'(o_state), 32'd1);
      end
      check_outs("resettle_done", 3, 0, 0, 0, 1);
      half(1'b1, 14'sd10, 3, 1'b0, '0, 1'b1);
      half(1'b0, -14'sd10, 3, 1'b0, '0, 1'b1);
      check_outs("resettle_win", 3, 60, 1, 15, 1);

      // Asynchronous reset mid-window
      i_status  = 1'b1;
      i_err     = 14'sd10;
      i_err_vld = 1'b1;
      tick();
      tick();
      #2;
      i_rst = 1'b1;
      #1;
      check_outs("async_rst", 0, 0, 0, 0, 0);
      tick();
      check_outs("rst_held", 0, 0, 0, 0, 0);
      i_err_vld = 1'b0;
      i_rst     = 1'b0;
      tick();
      check_outs("rst_reenable", 1, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fog_loop_ctrl.md
Name: fog_loop_ctrl

Overview:
Closed-loop sequencer for the miniFOG phase-ramp feedback path.
- Demodulates gyro error samples against the modulation half-period indicator and accumulates them over a window of step triggers.
- Reports the open-loop rate.
- In closed loop, integrates the scaled error into the ramp step word and drives the ramp generator's feedback enable.
- Sits between the modulation generator (trigger/status), the error ADC front end, and the phase-ramp generator's step and feedback-enable inputs.

Parameters:
ERR_BIT, 14, width of signed error sample
SETTLE_CNT, 16, trigger pulses discarded after enable before any window is evaluated
AVG_LOG2, 3, window length = 2^AVG_LOG2 trigger pulses
STEP_LIM, 100000, positive saturation magnitude of o_step (symmetric, ±STEP_LIM)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_en  in  1  loop enable
i_trig  in  1  one-cycle step trigger from modulation generator (one per half-period)
i_status  in  1  modulation half indicator, 1 = high half
i_err  in  ERR_BIT  signed error sample
i_err_vld  in  1  i_err valid strobe
i_gain_sft  in  5  arithmetic right shift applied to window sum before integration
i_fb_req  in  1  request closed-loop operation
o_step  out  32  signed step word to ramp generator
o_fb_on  out  1  feedback enable to ramp generator
o_rate  out  32  signed last window sum
o_rate_vld  out  1  one-cycle pulse when o_rate updates
o_state  out  2  0 IDLE, 1 SETTLE, 2 OPEN, 3 CLOSED

Behaviour:
- Reset (i_rst=1, async): state IDLE; o_step=0, o_fb_on=0, o_rate=0, o_rate_vld=0, acc=0, all counters 0.
- Demodulation: on i_err_vld, acc += sext(i_err) if i_status=1, else acc -= sext(i_err). acc is 32-bit two's complement with no saturation. Sizing guarantees no overflow for ERR_BIT≤16 and window ≤2^12 samples.
- Window close: occurs on the trigger pulse that completes 2^AVG_LOG2 triggers since the last close.
  - An i_err_vld in the same cycle as the closing i_trig is included in the closing sum.
  - At that clock edge: o_rate <= sum, o_rate_vld=1 for exactly one cycle (visible the cycle after i_trig), acc cleared.
- IDLE: all outputs held at reset values. i_en=1 -> SETTLE on the next edge.
- SETTLE: counts i_trig pulses; acc is held at 0 (samples discarded). On the SETTLE_CNT-th trigger -> CLOSED if i_fb_req=1, else OPEN. The window counter starts at 0 on entry to OPEN/CLOSED.
- OPEN: o_fb_on=0, o_step=0. Windows produce o_rate. At a window close with i_fb_req=1 -> CLOSED (that window's sum is reported but not integrated).
- CLOSED: o_fb_on=1.
  - At each window close: o_step <= sat(o_step + (sum >>> i_gain_sft)), clamped to [-STEP_LIM, +STEP_LIM]. o_rate is also updated.
  - At a window close with i_fb_req=0 -> OPEN, and o_step is cleared to 0 on the same edge (no integration that window).
- i_fb_req is evaluated only at window close; changes mid-window have no effect until then.
- i_en=0 in any state: next edge -> IDLE, with acc, counters, o_step, o_fb_on, o_rate and o_rate_vld cleared. This takes priority over a simultaneous window close.
- Latency: o_step, o_fb_on and o_rate change one cycle after the sampled i_trig. o_step is stable between trigger pulses, so the ramp generator always latches a settled value.
- Async reset mid-window: immediate return to reset values, with no partial-window output.

Test Plan:
1. Parameters SETTLE_CNT=4, AVG_LOG2=1. Set i_en=1, i_fb_req=0, 3 samples per half at +10 (status=1) / -10 (status=0) -> o_state 1 for 4 triggers, then 2; o_rate=60 with o_rate_vld pulse every 2 triggers; o_step=0, o_fb_on=0.
2. Same stimulus with i_fb_req=1, i_gain_sft=2 -> o_state=3, o_fb_on=1, o_step = 15, 30, 45 ... at successive window closes, each one cycle after the closing trigger.
3. STEP_LIM=100, sum=60, gain 0 -> o_step 60, 100, 100; with sign-reversed error, o_step goes 100, 40, -20, ... and clamps at -100.
4. In CLOSED with o_step=45, drop i_fb_req mid-window -> no change until close; at close o_state=2, o_step=0, o_fb_on=0, o_rate still updated.
5. Assert i_err_vld coincident with the closing i_trig, sample +7 in high half -> that sample is included in the reported o_rate and is not present in the next window.
6. i_en=0 in the same cycle as a closing trigger, then async i_rst pulse mid-window in CLOSED -> IDLE with all outputs 0, no o_rate_vld pulse; re-enable runs SETTLE again.
